// File: rtl/mem_responder.sv
// mem_responder: word-organised memory with byte-lane writes that answers each
// read/write request after a fixed, programmable latency and flags requester
// protocol violations with a sticky error bit.
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        protocol_error
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [3:0]            count;
  logic                  cap_write;
  logic [31:0]           cap_addr;
  logic [3:0]            cap_be;
  logic [31:0]           cap_wdata;
  logic [31:0]           mem_array [DEPTH];

  logic                  req_valid;
  logic                  req_both;
  logic                  req_mismatch;
  logic                  violation;
  logic                  enter_resp;
  logic                  eff_write;
  logic [3:0]            eff_be;
  logic [31:0]           eff_wdata;
  logic [DEPTH_LOG2-1:0] eff_index;

  // Classify the live request and compare it against the captured transaction
  always_comb begin
    req_valid    = mem_read ^ mem_write;
    req_both     = mem_read & mem_write;
    req_mismatch = (cap_write ? !(mem_write && !mem_read) : !(mem_read && !mem_write))
                   || (mem_address != cap_addr);
  end

  // Next-state and output decode; outputs default low, state defaults to hold
  always_comb begin
    state_next = state;
    mem_resp   = 1'b0;
    violation  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_next = (LAT == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        violation = req_mismatch;
        if (count == 4'd1) state_next = RESP;
      end
      RESP: begin
        mem_resp   = 1'b1;
        violation  = req_mismatch;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero latency the array access happens on the capture edge itself,
  // so the operands come straight from the inputs while still in IDLE
  always_comb begin
    enter_resp = (state_next == RESP);
    if (state == IDLE) begin
      eff_write = mem_write;
      eff_be    = mem_byte_enable;
      eff_wdata = mem_wdata;
      eff_index = mem_address[DEPTH_LOG2+1:2];
    end else begin
      eff_write = cap_write;
      eff_be    = cap_be;
      eff_wdata = cap_wdata;
      eff_index = cap_addr[DEPTH_LOG2+1:2];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Request capture, latency counter, read data register and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      count          <= 4'd0;
      mem_rdata      <= 32'd0;
      protocol_error <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (req_valid) begin
          cap_write <= mem_write;
          cap_addr  <= mem_address;
          cap_be    <= mem_byte_enable;
          cap_wdata <= mem_wdata;
          count     <= LAT;
        end
        if (req_both) protocol_error <= 1'b1;
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end
      if (violation) protocol_error <= 1'b1;
      if (enter_resp && !eff_write) mem_rdata <= mem_array[eff_index];
    end
  end

  // Byte-lane write commit on the edge entering RESP; a reset on that edge cancels it
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && eff_write) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_be[i]) mem_array[eff_index][8*i +: 8] <= eff_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder. Instance 0 uses
// LATENCY=2, instance 1 LATENCY=0, instance 2 LATENCY=15.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] addr  [3];
  logic [3:0]  be    [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        resp  [3];
  logic        perr  [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          dut;
    logic        is_read;
    logic [31:0] rdata;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_address(addr[0]), .mem_byte_enable(be[0]), .mem_wdata(wdata[0]),
    .mem_rdata(rdata[0]), .mem_resp(resp[0]), .protocol_error(perr[0])
  );

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) dut_lat0 (
    .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_address(addr[1]), .mem_byte_enable(be[1]), .mem_wdata(wdata[1]),
    .mem_rdata(rdata[1]), .mem_resp(resp[1]), .protocol_error(perr[1])
  );

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(15)) dut_lat15 (
    .clk(clk), .rst(rst), .mem_read(rd[2]), .mem_write(wr[2]),
    .mem_address(addr[2]), .mem_byte_enable(be[2]), .mem_wdata(wdata[2]),
    .mem_rdata(rdata[2]), .mem_resp(resp[2]), .protocol_error(perr[2])
  );

  // Cycles from the request cycle to the mem_resp cycle for each instance
  function automatic int respDelay(input int d);
    case (d)
      0:       return 3;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the response just seen
  task automatic checkResponse(input int d, input logic got, input int cycles);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput({e.tag, "_resp"}, {31'd0, got}, 32'd1);
    checkOutput({e.tag, "_dut"}, 32'(d), 32'(e.dut));
    if (got) begin
      checkOutput({e.tag, "_latency"}, 32'(cycles), 32'(e.lat));
      if (e.is_read) checkOutput({e.tag, "_rdata"}, rdata[d], e.rdata);
    end
  endtask

  // One complete transaction; drop_at>0 releases the request after that many edges
  task automatic applyStimulus(input int d, input string tag, input logic is_write,
                               input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] wd, input logic [31:0] exp_rd,
                               input int drop_at);
    exp_t e;
    int   n;
    logic got;
    e.dut     = d;
    e.is_read = !is_write;
    e.rdata   = exp_rd;
    e.lat     = respDelay(d);
    e.tag     = tag;
    sb.push_back(e);
    rd[d]    = !is_write;
    wr[d]    = is_write;
    addr[d]  = a;
    be[d]    = b;
    wdata[d] = wd;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == drop_at) begin
        rd[d] = 1'b0;
        wr[d] = 1'b0;
      end
      if (resp[d]) got = 1'b1;
    end
    checkResponse(d, got, n);
    @(posedge clk); #1;
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    checkOutput({tag, "_pulse"}, {31'd0, resp[d]}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0;
      wr[i] = 1'b0;
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; be[i] = 4'd0; wdata[i] = 32'd0;
    end
    resetDut();
    checkOutput("reset_resp", {31'd0, resp[0]}, 32'd0);
    checkOutput("reset_rdata", rdata[0], 32'd0);
    checkOutput("reset_perr", {31'd0, perr[0]}, 32'd0);

    // Basic write then read at latency 2
    applyStimulus(0, "wr_10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 0);
    applyStimulus(0, "rd_10", 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 0);

    // Byte and halfword lane writes
    applyStimulus(0, "wr_20", 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 0);
    applyStimulus(0, "sb_20", 1'b1, 32'h20, 4'b0100, 32'h00AA0000, 32'h0, 0);
    applyStimulus(0, "rd_20a", 1'b0, 32'h20, 4'h0, 32'h0, 32'h11AA3344, 0);
    applyStimulus(0, "sh_20", 1'b1, 32'h20, 4'b0011, 32'h0000BEEF, 32'h0, 0);
    applyStimulus(0, "rd_20b", 1'b0, 32'h20, 4'h0, 32'h0, 32'h11AABEEF, 0);

    // Address wrap and ignored low bits
    applyStimulus(0, "wr_1000", 1'b1, 32'h1000, 4'hF, 32'h5, 32'h0, 0);
    applyStimulus(0, "rd_0", 1'b0, 32'h0, 4'h0, 32'h0, 32'h5, 0);
    applyStimulus(0, "rd_23", 1'b0, 32'h23, 4'h0, 32'h0, 32'h11AABEEF, 0);

    // Write with no lanes enabled leaves the word untouched
    applyStimulus(0, "wr_be0", 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'h0, 0);
    applyStimulus(0, "rd_be0", 1'b0, 32'h20, 4'h0, 32'h0, 32'h11AABEEF, 0);
    checkOutput("perr_clean", {31'd0, perr[0]}, 32'd0);

    // Read and write together in IDLE: ignored, error latched
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h10;
    @(posedge clk); #1;
    rd[0] = 1'b0; wr[0] = 1'b0;
    checkOutput("both_perr", {31'd0, perr[0]}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("both_noresp", {31'd0, resp[0]}, 32'd0);
      @(posedge clk); #1;
    end
    applyStimulus(0, "rd_after_both", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 0);
    checkOutput("perr_sticky", {31'd0, perr[0]}, 32'd1);

    // Request dropped during WAIT still completes once and flags an error
    resetDut();
    checkOutput("perr_cleared", {31'd0, perr[0]}, 32'd0);
    applyStimulus(0, "rd_drop", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1);
    checkOutput("drop_perr", {31'd0, perr[0]}, 32'd1);

    // Reset on the edge that would commit a write cancels it
    resetDut();
    applyStimulus(0, "wr_40_zero", 1'b1, 32'h40, 4'hF, 32'h0, 32'h0, 0);
    wr[0] = 1'b1; addr[0] = 32'h40; be[0] = 4'hF; wdata[0] = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("midrst_wait", {31'd0, resp[0]}, 32'd0);
    rst = 1'b1; wr[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("midrst_noresp", {31'd0, resp[0]}, 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("midrst_perr", {31'd0, perr[0]}, 32'd0);
    checkOutput("midrst_rdata", rdata[0], 32'd0);
    applyStimulus(0, "rd_40", 1'b0, 32'h40, 4'h0, 32'h0, 32'h0, 0);

    // Latency extremes
    applyStimulus(1, "l0_wr", 1'b1, 32'h8, 4'hF, 32'h12345678, 32'h0, 0);
    applyStimulus(1, "l0_rd", 1'b0, 32'h8, 4'h0, 32'h0, 32'h12345678, 0);
    applyStimulus(2, "l15_wr", 1'b1, 32'h8, 4'hF, 32'h87654321, 32'h0, 0);
    applyStimulus(2, "l15_rd", 1'b0, 32'h8, 4'h0, 32'h0, 32'h87654321, 0);
    checkOutput("l0_perr", {31'd0, perr[1]}, 32'd0);
    checkOutput("l15_perr", {31'd0, perr[2]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
